// File: rtl/pushbutton_event_decoder.sv
// pushbutton_event_decoder: turns debounced button edges into click, double-click, long-press and auto-repeat pulses
module pushbutton_event_decoder #(
  parameter int CNT_W      = 24,
  parameter int LONG_CYC   = 10000000,
  parameter int DCLICK_CYC = 5000000,
  parameter int REPEAT_CYC = 2500000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pb_state_i,
  input  logic       pb_down_i,
  input  logic       pb_up_i,
  output logic       click_o,
  output logic       dclick_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       busy_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;
  localparam longint TMAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_LIM = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC - 1);
  localparam bit REP_ON = REPEAT_CYC != 0;
  if (LONG_CYC == 0 || DCLICK_CYC == 0 || longint'(LONG_CYC) > TMAX ||
      longint'(DCLICK_CYC) > TMAX || longint'(REPEAT_CYC) > TMAX) begin : g_bad_param
    $error("pushbutton_event_decoder: timing parameter out of range for CNT_W");
  end
  state_t state;
  logic [CNT_W-1:0] timer;
  assign state_o = state;
  // Event FSM: timer restarts on every state entry, simultaneous down/up edges freeze the state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      timer    <= '0;
      click_o  <= 1'b0;
      dclick_o <= 1'b0;
      long_o   <= 1'b0;
      repeat_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      click_o  <= 1'b0;
      dclick_o <= 1'b0;
      long_o   <= 1'b0;
      repeat_o <= 1'b0;
      timer    <= &timer ? timer : timer + 1'b1;
      if (!(pb_down_i && pb_up_i)) begin
        unique case (state)
          IDLE:
            if (pb_down_i) begin
              state  <= PRESS1;
              timer  <= '0;
              busy_o <= 1'b1;
            end
          PRESS1:
            if (pb_up_i) begin
              state <= WAIT2;
              timer <= '0;
            end else if (!pb_state_i) begin
              state  <= IDLE;
              timer  <= '0;
              busy_o <= 1'b0;
            end else if (timer == LONG_LIM) begin
              state  <= HELD;
              timer  <= '0;
              long_o <= 1'b1;
            end
          WAIT2:
            if (pb_down_i) begin
              state <= PRESS2;
              timer <= '0;
            end else if (timer == DCLK_LIM) begin
              state   <= IDLE;
              timer   <= '0;
              busy_o  <= 1'b0;
              click_o <= 1'b1;
            end
          PRESS2:
            if (pb_up_i) begin
              state    <= IDLE;
              timer    <= '0;
              busy_o   <= 1'b0;
              dclick_o <= 1'b1;
            end else if (!pb_state_i) begin
              state  <= IDLE;
              timer  <= '0;
              busy_o <= 1'b0;
            end else if (timer == LONG_LIM) begin
              state    <= HELD;
              timer    <= '0;
              dclick_o <= 1'b1;
            end
          HELD:
            if (pb_up_i || !pb_state_i) begin
              state  <= IDLE;
              timer  <= '0;
              busy_o <= 1'b0;
            end else if (REP_ON && timer == REP_LIM) begin
              timer    <= '0;
              repeat_o <= 1'b1;
            end
          default: begin
            state  <= IDLE;
            timer  <= '0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/pushbutton_event_decoder.md
PUSHBUTTON_EVENT_DECODER -- requirements
Module: pushbutton_event_decoder

Interface
REQ-001 Parameter CNT_W, default 24: width of the internal event timer.
REQ-002 Parameter LONG_CYC, default 10000000: clock cycles a press must last to count as long.
REQ-003 Parameter DCLICK_CYC, default 5000000: maximum clock cycles from first release to second press for a double click.
REQ-004 Parameter REPEAT_CYC, default 2500000: auto-repeat period while held after a long press; 0 disables repeat.
REQ-005 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 pb_state_i  input  1  debounced button level, 1 = pressed.
REQ-008 pb_down_i  input  1  one-cycle pulse when the button has just been pressed.
REQ-009 pb_up_i  input  1  one-cycle pulse when the button has just been released.
REQ-010 click_o  output  1  one-cycle pulse for a confirmed single short click.
REQ-011 dclick_o  output  1  one-cycle pulse for a confirmed double click.
REQ-012 long_o  output  1  one-cycle pulse when a first press reaches LONG_CYC.
REQ-013 repeat_o  output  1  one-cycle pulse every REPEAT_CYC cycles while in HELD.
REQ-014 busy_o  output  1  1 whenever the state is not IDLE.
REQ-015 state_o  output  3  current state encoding: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HELD=4.

Function
REQ-016 All outputs SHALL be registered; each event output SHALL be high for exactly one cycle, in the cycle after its trigger edge.
REQ-017 On every state entry the timer SHALL be cleared to 0; otherwise it SHALL increment by 1 per cycle and saturate at all-ones.
REQ-018 A timeout for limit L SHALL fire on the edge where timer == L-1, i.e. after L cycles in the state.
REQ-019 IDLE: pb_down_i SHALL move to PRESS1; all other inputs are ignored, including pb_state_i=1 without a pb_down_i, e.g. a button held through reset.
REQ-020 PRESS1: pb_up_i SHALL move to WAIT2; a LONG_CYC timeout SHALL move to HELD and pulse long_o.
REQ-021 WAIT2: pb_down_i SHALL move to PRESS2; a DCLICK_CYC timeout SHALL move to IDLE and pulse click_o.
REQ-022 PRESS2: pb_up_i SHALL move to IDLE and pulse dclick_o; a LONG_CYC timeout SHALL move to HELD and pulse dclick_o (not long_o).
REQ-023 HELD: when REPEAT_CYC>0, repeat_o SHALL pulse on every REPEAT_CYC timeout, with the timer restarting at 0; pb_up_i SHALL move to IDLE with no further pulse.
REQ-024 In PRESS1, PRESS2 or HELD, pb_state_i=0 without pb_up_i (a missed release) SHALL move to IDLE with no event pulse.
REQ-025 pb_down_i and pb_up_i high in the same cycle SHALL be ignored: state unchanged, timer continues.
REQ-026 If pb_up_i arrives in the same cycle as a timeout, pb_up_i SHALL take precedence.
REQ-027 Elaboration SHALL fail if LONG_CYC, DCLICK_CYC or REPEAT_CYC exceed 2^CNT_W-1, or if LONG_CYC or DCLICK_CYC equal 0.

Reset
REQ-028 rstn_i=0 SHALL immediately force state IDLE, timer 0 and all outputs 0, regardless of the clock.
REQ-029 After release of rstn_i, the first event SHALL require a fresh pb_down_i.

Verification
Parameters for all scenarios: LONG_CYC=100, DCLICK_CYC=50, REPEAT_CYC=20. Cycle numbers are relative to the input pulse.
REQ-030 Short click: pb_down_i at cycle 0, pb_up_i at cycle 10 -> click_o high only in cycle 61; no other pulses; busy_o low from cycle 61.
REQ-031 Double click: down at 0, up at 10, down at 40, up at 50 -> dclick_o high only in cycle 51; click_o never asserted.
REQ-032 Long press with repeat: down at 0, up at 200 -> long_o in cycle 101; repeat_o in cycles 121, 141, 161, 181; exactly 4 repeat pulses; IDLE in cycle 201.
REQ-033 Missed release: down at 0, pb_state_i dropped at 30 with no pb_up_i -> IDLE in cycle 31; no event pulses.
REQ-034 Reset mid-operation: rstn_i asserted at cycle 150 of a long hold -> outputs 0 and state_o=0 asynchronously; a held pb_state_i=1 after reset produces no events until pb_down_i.
REQ-035 Boundary and precedence: with REPEAT_CYC=0, a 300-cycle hold -> one long_o and zero repeat_o; pb_down_i and pb_up_i together in IDLE -> state_o stays 0.
